// File: rtl/spi_reg_responder_if.sv
// SPI wires between a spi_driver (master) and the register responder (slave).
interface spi_reg_responder_if;
  logic spi_clk;
  logic serial_in;
  logic serial_out;

  modport master (output spi_clk, output serial_in, input serial_out);
  modport slave  (input spi_clk, input serial_in, output serial_out);
endinterface

// File: rtl/spi_reg_responder.sv
// SPI register target: 8-bit address then 8-bit data, returns the pre-write value, commits RW writes.
// spi_clk is oversampled in clk; frames are delimited by spi_clk idle timeout.
module spi_reg_responder #(
  parameter int NUM_RW_REGS  = 8,
  parameter int NUM_RO_REGS  = 8,
  parameter int IDLE_TIMEOUT = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  spi_reg_responder_if.slave       spi,
  input  logic [8*NUM_RO_REGS-1:0] status_i,
  output logic [8*NUM_RW_REGS-1:0] regs_o,
  output logic                     wr_strobe_o,
  output logic [7:0]               wr_addr_o,
  output logic                     bad_addr_o,
  output logic                     frame_err_o
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
  localparam logic [8:0] RW_END = 9'(NUM_RW_REGS);
  localparam logic [8:0] RO_END = 9'(NUM_RW_REGS + NUM_RO_REGS);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_COMMIT, S_POST} state_e;

  logic [SYNC_STAGES-1:0]   sclk_sync_q, sin_sync_q;
  logic                     sclk_prev_q;
  state_e                   state_q, state_d;
  logic [4:0]               bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]            idle_q, idle_d;
  logic [7:0]               addr_q, addr_d;
  logic [7:0]               data_q, data_d;
  logic [7:0]               tx_q, tx_d;
  logic                     loaded_q, loaded_d;
  logic [8*NUM_RW_REGS-1:0] regs_q, regs_d;
  logic                     wr_strobe_q, wr_strobe_d;
  logic [7:0]               wr_addr_q, wr_addr_d;
  logic                     bad_addr_q, bad_addr_d;
  logic                     frame_err_q, frame_err_d;

  logic       sclk_s, sin_s, rise, fall, timeout;
  logic [7:0] rd_val;
  logic [8:0] addr9;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign sin_s   = sin_sync_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;
  assign timeout = (idle_q == IDLE_MAX) && !rise && !fall;
  assign addr9   = {1'b0, addr_q};

  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < NUM_RW_REGS; k++)
      if (addr9 == 9'(k)) rd_val = regs_q[8*k +: 8];
    for (int k = 0; k < NUM_RO_REGS; k++)
      if (addr9 == 9'(NUM_RW_REGS + k)) rd_val = status_i[8*k +: 8];
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tx_d        = tx_q;
    loaded_d    = loaded_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    bad_addr_d  = 1'b0;
    frame_err_d = 1'b0;

    if (rise || fall || sclk_s) idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
    else idle_d = idle_q;

    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          addr_d    = {7'b0, sin_s};
          bit_cnt_d = 5'd1;
          tx_d      = 8'h00;
          loaded_d  = 1'b0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rise) begin
          addr_d    = {addr_q[6:0], sin_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) state_d = S_DATA;
        end else if (timeout) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = 5'd0;
          state_d     = S_IDLE;
        end
      end
      S_DATA: begin
        if (rise) begin
          data_d    = {data_q[6:0], sin_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) state_d = S_COMMIT;
        end else if (fall) begin
          // Read value is captured once, at the first fall of the data byte.
          if (!loaded_q) begin
            tx_d     = rd_val;
            loaded_d = 1'b1;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = 5'd0;
          state_d     = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (addr9 < RW_END) begin
          for (int k = 0; k < NUM_RW_REGS; k++)
            if (addr9 == 9'(k)) regs_d[8*k +: 8] = data_q;
          wr_strobe_d = 1'b1;
          wr_addr_d   = addr_q;
        end else if (addr9 >= RO_END) begin
          bad_addr_d = 1'b1;
        end
        state_d = S_POST;
      end
      // Surplus rises after a committed frame are swallowed until the line goes idle.
      S_POST: begin
        if (timeout) begin
          bit_cnt_d = 5'd0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      sin_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      idle_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_q        <= '0;
      loaded_q    <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      bad_addr_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.spi_clk};
      sin_sync_q  <= {sin_sync_q[SYNC_STAGES-2:0], spi.serial_in};
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_q      <= idle_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      loaded_q    <= loaded_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      bad_addr_q  <= bad_addr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi.serial_out = (state_q == S_DATA) ? tx_q[7] : 1'b0;
  assign regs_o         = regs_q;
  assign wr_strobe_o    = wr_strobe_q;
  assign wr_addr_o      = wr_addr_q;
  assign bad_addr_o     = bad_addr_q;
  assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed and random SPI frames against an array model of the register file.
module tb_spi_reg_responder;
  localparam int NRW  = 8;
  localparam int NRO  = 8;
  localparam int TO   = 64;
  localparam int SS   = 2;
  localparam int HALF = 6;
  localparam int GAP  = TO + SS + 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_reg_responder_if sif();
  logic [8*NRO-1:0] status;
  logic [8*NRW-1:0] regs;
  logic             wr_strobe, bad_addr, frame_err;
  logic [7:0]       wr_addr;

  spi_reg_responder #(
    .NUM_RW_REGS(NRW), .NUM_RO_REGS(NRO), .IDLE_TIMEOUT(TO), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst(rst), .spi(sif), .status_i(status), .regs_o(regs),
    .wr_strobe_o(wr_strobe), .wr_addr_o(wr_addr), .bad_addr_o(bad_addr), .frame_err_o(frame_err)
  );

  int total = 0;
  int bad   = 0;
  int n_wr = 0, n_bad = 0, n_ferr = 0;
  logic [7:0] mdl [NRW];

  always @(negedge clk) begin
    if (wr_strobe) n_wr++;
    if (bad_addr)  n_bad++;
    if (frame_err) n_ferr++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mdl_pack();
    logic [63:0] p;
    for (int k = 0; k < NRW; k++) p[8*k +: 8] = mdl[k];
    return p;
  endfunction

  function automatic logic [7:0] mdl_read(input logic [7:0] a);
    if (a < NRW) return mdl[a];
    if (a < NRW + NRO) return status[8*(a-NRW) +: 8];
    return 8'h00;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input int nbits,
                       output logic [7:0] rx);
    logic [15:0] w;
    w  = {a, d};
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sif.serial_in = (i < 16) ? w[15-i] : 1'b0;
      tick(HALF);
      if (i >= 8 && i < 16) rx[15-i] = sif.serial_out;
      sif.spi_clk = 1'b1;
      tick(HALF);
      sif.spi_clk = 1'b0;
    end
    sif.serial_in = 1'b0;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] a, input logic [7:0] d,
                          input int nbits);
    int w0, b0, f0;
    logic [7:0] rx, exp_rd;
    exp_rd = mdl_read(a);
    w0 = n_wr; b0 = n_bad; f0 = n_ferr;
    frame(a, d, nbits, rx);
    tick(GAP);
    check({tag, ".rd"}, 64'(rx), 64'(exp_rd));
    check({tag, ".wr_cnt"}, 64'(n_wr - w0), (a < NRW) ? 64'd1 : 64'd0);
    check({tag, ".bad_cnt"}, 64'(n_bad - b0), (a >= NRW + NRO) ? 64'd1 : 64'd0);
    check({tag, ".ferr_cnt"}, 64'(n_ferr - f0), 64'd0);
    if (a < NRW) begin
      mdl[a] = d;
      check({tag, ".wr_addr"}, 64'(wr_addr), 64'(a));
    end
    check({tag, ".regs"}, regs, mdl_pack());
  endtask

  initial begin
    logic [7:0] rx;
    int w0, f0;
    logic [7:0] ra, rd;
    int nb;
    for (int k = 0; k < NRW; k++) mdl[k] = 8'h00;
    rst = 1'b1; sif.spi_clk = 1'b0; sif.serial_in = 1'b0; status = '0;
    tick(4);
    rst = 1'b0;
    tick(2);
    check("rst.regs", regs, 64'd0);
    check("rst.wr_strobe", 64'(wr_strobe), 64'd0);
    check("rst.wr_addr", 64'(wr_addr), 64'd0);
    check("rst.bad_addr", 64'(bad_addr), 64'd0);
    check("rst.frame_err", 64'(frame_err), 64'd0);
    check("rst.serial_out", 64'(sif.serial_out), 64'd0);

    do_frame("t1", 8'h01, 8'hAA, 16);
    do_frame("t2", 8'h01, 8'h02, 16);
    status[7:0] = 8'h5C;
    do_frame("t3", 8'h08, 8'hFF, 16);
    do_frame("t4", 8'h20, 8'h11, 16);
    do_frame("ro_top", 8'h0F, 8'h33, 16);
    do_frame("rw_top", 8'h07, 8'hC3, 16);
    do_frame("first_bad", 8'h10, 8'h44, 16);
    do_frame("extra_rises", 8'h04, 8'h5A, 19);

    // Aborted frame: no pulse before the timeout elapses, exactly one after.
    w0 = n_wr; f0 = n_ferr;
    frame(8'h02, 8'h99, 11, rx);
    tick(TO - 4);
    check("t5.ferr_early", 64'(n_ferr - f0), 64'd0);
    tick(SS + 2 + 4 + 4);
    check("t5.ferr_cnt", 64'(n_ferr - f0), 64'd1);
    check("t5.wr_cnt", 64'(n_wr - w0), 64'd0);
    check("t5.regs", regs, mdl_pack());
    tick(GAP);
    do_frame("t5b", 8'h03, 8'h77, 16);

    // Reset in the middle of the data byte.
    w0 = n_wr;
    frame(8'h05, 8'h3C, 12, rx);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    for (int k = 0; k < NRW; k++) mdl[k] = 8'h00;
    check("t6.wr_cnt", 64'(n_wr - w0), 64'd0);
    check("t6.regs", regs, 64'd0);
    check("t6.wr_addr", 64'(wr_addr), 64'd0);
    check("t6.serial_out", 64'(sif.serial_out), 64'd0);
    do_frame("t6b", 8'h05, 8'h3C, 16);

    for (int n = 0; n < 24; n++) begin
      status = {$urandom, $urandom};
      ra = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 19));
      rd = 8'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? 17 + $urandom_range(0, 3) : 16;
      do_frame("rnd", ra, rd, nb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
